// File: rtl/mux_arb_reg.sv
`default_nettype none
// ============================================================================
// Module   : mux_arb_reg
// Brief    : N-to-1 channel selector with valid/ready handshakes, explicit-
//            select or round-robin arbitration, and a registered output
//            stage that sustains one word per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module mux_arb_reg #(
  parameter int N     = 15,   // number of input channels (2..32)
  parameter int W     = 32,   // data width per channel
  parameter int SEL_W = 4     // select width, 2**SEL_W >= N
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N*W-1:0]   in_data,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  input  logic             mode,
  input  logic [SEL_W-1:0] select,
  output logic [W-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SEL_W-1:0] out_sel,
  output logic             out_oor
);

  // Channel count widened by one bit so wrap arithmetic cannot overflow.
  localparam logic [SEL_W:0]   N_EXT   = (SEL_W+1)'(N);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N-1);

  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] rr_next;
  logic [SEL_W-1:0] chan;
  logic             oor_now;
  logic             load_en;
  logic             grant;
  logic [W-1:0]     chan_data;
  logic [SEL_W:0]   idx;
  logic             found;

  // The output register can accept a word when empty or being drained.
  assign load_en = !out_valid || out_ready;

  // Channel after the last round-robin winner, wrapping at N-1.
  always_comb begin
    rr_next = (rr_ptr == LAST_CH) ? '0 : rr_ptr + 1'b1;
  end

  // Pick the candidate channel: explicit select (with out-of-range fallback
  // to the last channel) or the first requester after the last winner.
  always_comb begin
    chan    = rr_next;
    oor_now = 1'b0;
    found   = 1'b0;
    idx     = '0;
    if (!mode) begin
      if ({1'b0, select} < N_EXT) begin
        chan = select;
      end else begin
        chan    = LAST_CH;
        oor_now = 1'b1;
      end
    end else begin
      for (int i = 1; i <= N; i++) begin
        idx = {1'b0, rr_ptr} + (SEL_W+1)'(i);
        if (idx >= N_EXT) begin
          idx = idx - N_EXT;
        end
        if (!found && in_valid[idx[SEL_W-1:0]]) begin
          found = 1'b1;
          chan  = idx[SEL_W-1:0];
        end
      end
    end
  end

  // Data word of the candidate channel.
  always_comb begin
    chan_data = '0;
    for (int k = 0; k < N; k++) begin
      if (chan == SEL_W'(k)) begin
        chan_data = in_data[k*W +: W];
      end
    end
  end

  // A transfer happens when the candidate is requesting and we can load.
  assign grant = in_valid[chan] && load_en;

  // Only the candidate channel sees ready, and only when the stage can load.
  generate
    for (genvar k = 0; k < N; k++) begin : g_ready
      assign in_ready[k] = (chan == SEL_W'(k)) && load_en;
    end
  endgenerate

  // Output stage: load on transfer, drop valid on drain, hold on stall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      out_oor   <= 1'b0;
    end else if (load_en) begin
      if (grant) begin
        out_valid <= 1'b1;
        out_data  <= chan_data;
        out_sel   <= chan;
        out_oor   <= oor_now;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  // Round-robin pointer follows the last winner; starts at N-1 so that
  // channel 0 is favoured first after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= LAST_CH;
    end else if (mode && grant) begin
      rr_ptr <= chan;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mux_arb_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_arb_reg
// Brief    : Directed + randomized bench for mux_arb_reg against a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_arb_reg;

  localparam int N     = 15;
  localparam int W     = 32;
  localparam int SEL_W = 4;

  logic             clk;
  logic             reset_n;
  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_valid;
  logic [N-1:0]     in_ready;
  logic             mode;
  logic [SEL_W-1:0] select;
  logic [W-1:0]     out_data;
  logic             out_valid;
  logic             out_ready;
  logic [SEL_W-1:0] out_sel;
  logic             out_oor;

  mux_arb_reg #(.N(N), .W(W), .SEL_W(SEL_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .select    (select),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sel   (out_sel),
    .out_oor   (out_oor)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  // Per-channel data words offered by the producers.
  logic [W-1:0] d [N];

  // Reference model state: the held word and the last round-robin winner.
  bit           m_valid;
  logic [W-1:0] m_data;
  int           m_sel;
  bit           m_oor;
  int           m_rr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_sel   = 0;
    m_oor   = 1'b0;
    m_rr    = N - 1;
  endtask

  task automatic check_out();
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("out_data",  64'(out_data),  64'(m_data));
    chk("out_sel",   64'(out_sel),   64'(m_sel));
    chk("out_oor",   64'(out_oor),   64'(m_oor));
  endtask

  // Which channel the rules offer this cycle, and whether select was out of range.
  task automatic pick(output int ch, output bit oor);
    oor = 1'b0;
    if (mode == 1'b0) begin
      if (int'(select) < N) begin
        ch = int'(select);
      end else begin
        ch  = N - 1;
        oor = 1'b1;
      end
    end else begin
      ch = (m_rr + 1) % N;
      // Walk the ring backwards so the nearest requester is the last written.
      for (int i = N; i >= 1; i--) begin
        if (in_valid[(m_rr + i) % N]) ch = (m_rr + i) % N;
      end
    end
  endtask

  // One clock: check ready in the low phase, then the registered outputs.
  task automatic cycle();
    int           ch;
    bit           oor;
    bit           ld;
    logic [N-1:0] exp_rdy;
    for (int k = 0; k < N; k++) in_data[k*W +: W] = d[k];
    @(negedge clk);
    pick(ch, oor);
    ld      = !m_valid || out_ready;
    exp_rdy = '0;
    if (ld) exp_rdy[ch] = 1'b1;
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    @(posedge clk);
    if (ld) begin
      if (in_valid[ch]) begin
        m_valid = 1'b1;
        m_data  = d[ch];
        m_sel   = ch;
        m_oor   = oor;
        if (mode) m_rr = ch;
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
    check_out();
  endtask

  task automatic do_reset();
    in_valid = '0;
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    mode      = 1'b0;
    select    = '0;
    out_ready = 1'b1;
    for (int k = 0; k < N; k++) d[k] = 32'h1000_0000 + 32'(k);
    model_reset();
    do_reset();

    // Explicit select of channel 3.
    mode     = 1'b0;
    select   = 4'd3;
    in_valid = 15'(1) << 3;
    d[3]     = 32'hA5A5_0003;
    cycle();
    in_valid = '0;
    cycle();

    // Out-of-range select falls back to channel 14 and flags it.
    select   = 4'd15;
    in_valid = 15'(1) << 14;
    d[14]    = 32'h0000_00EE;
    cycle();
    in_valid = '0;
    cycle();
    cycle();

    // Backpressure: hold a word for five cycles, then drain and reload.
    select    = 4'd2;
    in_valid  = 15'(1) << 2;
    d[2]      = 32'h2222_0001;
    cycle();
    d[2]      = 32'h2222_0002;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        mode   = 1'b1;
        select = 4'd7;
      end
      cycle();
    end
    mode      = 1'b0;
    select    = 4'd2;
    out_ready = 1'b1;
    cycle();
    in_valid  = '0;
    cycle();

    // Round-robin with every channel requesting: 0..14 then wrap to 0.
    do_reset();
    mode     = 1'b1;
    for (int i = 0; i <= N; i++) begin
      in_valid = '1;
      for (int k = 0; k < N; k++) d[k] = $urandom;
      cycle();
      chk("rr_seq", 64'(out_sel), 64'(i % N));
    end

    // Two requesters alternate, then a single requester wins repeatedly.
    do_reset();
    mode     = 1'b1;
    in_valid = (15'(1) << 5) | (15'(1) << 9);
    repeat (4) cycle();
    in_valid = 15'(1) << 5;
    repeat (3) cycle();

    // Asynchronous reset between edges while a word is held.
    in_valid = '1;
    cycle();
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_data",  64'(out_data),  64'd0);
    chk("arst_sel",   64'(out_sel),   64'd0);
    model_reset();
    in_valid = '0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_out();
    mode     = 1'b1;
    in_valid = '1;
    cycle();
    chk("post_rst_grant", 64'(out_sel), 64'd0);

    // Randomized traffic with occasional mode switches and backpressure.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < N; k++) d[k] = $urandom;
      in_valid  = ($urandom_range(0, 7) == 0) ? '1 : N'($urandom);
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      select    = SEL_W'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
